// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART transmitter.
//   uart_state_e               FSM state encoding (IDLE, START, DATA, PARITY, STOP)
//   uart_byte_t                8-bit byte type carried through the FIFO
//   UART_DEFAULT_DELAY_FRAMES  clock cycles per bit at 27 MHz / 115200 baud
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    typedef logic [7:0] uart_byte_t;

    localparam int UART_DEFAULT_DELAY_FRAMES = 234;

endpackage

// File: rtl/uart_tx_fifo_fifo.sv
// uart_fifo: synchronous first-word-fall-through FIFO feeding the transmitter.
//   clk, rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   push        write wdata_i (ignored when full)
//   wdata_i     write data
//   pop         drop the head entry (ignored when empty)
//   rdata_o     head entry, valid whenever empty is low
//   full/empty  occupancy flags
//   count       number of stored entries, 0..DEPTH
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter. Bytes arrive over a valid/ready
// handshake, queue in a FIFO and are sent back-to-back, LSB first.
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   tx_data     byte to send (bits above DATA_BITS-1 are ignored)
//   tx_valid    tx_data is valid; accepted when tx_ready is also high
//   tx_ready    FIFO can accept a byte (low while in reset)
//   uart_tx     registered serial line, idle high
//   busy        a frame is in flight or bytes are queued
//   fifo_count  number of queued bytes
// Build option: define UART_TX_PARITY_EN to insert a parity bit after the
// data bits (odd when PARITY_ODD = 1, even otherwise).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DELAY_FRAMES = UART_DEFAULT_DELAY_FRAMES,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 16,
    parameter bit PARITY_ODD   = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int TW = $clog2(DELAY_FRAMES);
`ifdef UART_TX_PARITY_EN
    localparam uart_byte_t DATA_MASK = uart_byte_t'((1 << DATA_BITS) - 1);
`endif

    uart_state_e state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic          stop_cnt_q, stop_cnt_d;
    uart_byte_t    shift_q, shift_d;
    logic          uart_tx_q, line_d;
    logic          ready_en_q;
    logic          tick;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    uart_byte_t    fifo_rdata;

`ifndef UART_TX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = PARITY_ODD;
`endif

    uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (tx_valid && tx_ready),
        .wdata_i (tx_data),
        .pop     (fifo_pop),
        .rdata_o (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign tick = (timer_q == TW'(DELAY_FRAMES - 1));

    // The line value is computed from the current state and registered, so
    // uart_tx trails the state register by exactly one cycle in every state.
    always_comb begin
        state_d    = state_q;
        timer_d    = tick ? '0 : timer_q + TW'(1);
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        fifo_pop   = 1'b0;
        line_d     = 1'b1;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    state_d  = START;
                end
            end
            START: begin
                line_d = 1'b0;
                if (tick) begin
                    bit_idx_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                line_d = shift_q[bit_idx_q];
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        stop_cnt_d = 1'b0;
`ifdef UART_TX_PARITY_EN
                        state_d    = PARITY;
`else
                        state_d    = STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                line_d = (^(shift_q & DATA_MASK)) ^ PARITY_ODD;
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                line_d = 1'b1;
                if (tick) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        // Chain straight into the next frame when data waits.
                        if (!fifo_empty) begin
                            fifo_pop = 1'b1;
                            shift_d  = fifo_rdata;
                            state_d  = START;
                        end else begin
                            state_d  = IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                timer_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // ready_en_q keeps tx_ready low during reset and raises it on the first
    // clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            uart_tx_q  <= 1'b1;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            uart_tx_q  <= line_d;
            ready_en_q <= 1'b1;
        end
    end

    assign uart_tx  = uart_tx_q;
    assign tx_ready = ready_en_q && !fifo_full;
    assign busy     = (state_q != IDLE) || (fifo_count != '0);

endmodule
